// File: rtl/bgpu_fetch_pkg.sv
// Shared types for the warp fetch front end.
// Provides the program-counter, active-mask and warp-id types at their
// default widths, plus the per-warp scheduling state enum.
package bgpu_fetch_pkg;

  localparam int unsigned DefPcWidth   = 16;
  localparam int unsigned DefNumWarps  = 8;
  localparam int unsigned DefWarpWidth = 4;

  typedef logic [DefPcWidth-1:0]           pc_t;
  typedef logic [DefWarpWidth-1:0]         act_mask_t;
  typedef logic [$clog2(DefNumWarps)-1:0]  wid_t;

  typedef enum logic [1:0] {
    WARP_IDLE    = 2'd0,
    WARP_READY   = 2'd1,
    WARP_WAIT    = 2'd2,
    WARP_STOPPED = 2'd3
  } warp_state_e;

endpackage

// File: rtl/warp_rr_arbiter.sv
// Round-robin arbiter for the warp fetch scheduler.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-warp request (eligible) vector
//   advance    : grant accepted this cycle; pointer moves past the grant
//   valid      : some request is granted
//   grant      : index of the granted requester
// A grant that is presented but not accepted is locked, so a newly raised
// request cannot steal the slot while the consumer stalls.
module warp_rr_arbiter #(
  parameter int unsigned N    = 8,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic            valid,
  output logic [IdxW-1:0] grant
);

  logic [IdxW-1:0] ptr_q;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] search_idx;
  logic            found;
  int unsigned     idx;

  always_comb begin
    found      = 1'b0;
    search_idx = '0;
    idx        = 0;
    for (int i = 0; i < int'(N); i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        search_idx = IdxW'(idx);
      end
    end
    if (lock_q && req[lock_idx_q]) begin
      valid = 1'b1;
      grant = lock_idx_q;
    end else begin
      valid = found;
      grant = search_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (advance) begin
      ptr_q  <= IdxW'((int'(grant) + 1) % N);
      lock_q <= 1'b0;
    end else if (valid) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant;
    end else begin
      lock_q <= 1'b0;
    end
  end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// Warp fetch scheduler: picks one READY warp with instruction-buffer credit
// per cycle (round-robin) and presents its PC/mask to the instruction cache.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   set_ready_i            : (re)start all IDLE/STOPPED warps at StartPc
//   warp_active_o          : warp in READY or WAIT
//   warp_stopped_o         : warp in STOPPED
//   ib_pop_i               : per-warp instruction-buffer dequeue (returns credit)
//   ic_ready_i, fe_*       : fetch request handshake towards the I-cache
//   dec_*                  : decode feedback (next PC or stop) for a WAIT warp
// Optional macro WARP_FETCH_SCHED_ASSERT_EN compiles in protocol assertions.
//
// state   | meaning
// IDLE    | never started since reset
// READY   | may fetch when it holds credit
// WAIT    | fetch issued, awaiting decode result
// STOPPED | decoded a stop; waits for set_ready_i
module warp_fetch_scheduler
  import bgpu_fetch_pkg::*;
#(
  parameter int unsigned PcWidth        = DefPcWidth,
  parameter int unsigned NumWarps       = DefNumWarps,
  parameter int unsigned WarpWidth      = DefWarpWidth,
  parameter int unsigned IbDepthPerWarp = 4,
  parameter int unsigned StartPc        = 0,
  localparam int unsigned WidW          = $clog2(NumWarps)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 set_ready_i,
  output logic [NumWarps-1:0]  warp_active_o,
  output logic [NumWarps-1:0]  warp_stopped_o,
  input  logic [NumWarps-1:0]  ib_pop_i,
  input  logic                 ic_ready_i,
  output logic                 fe_valid_o,
  output logic [PcWidth-1:0]   fe_pc_o,
  output logic [WarpWidth-1:0] fe_act_mask_o,
  output logic [WidW-1:0]      fe_warp_id_o,
  input  logic                 dec_decoded_i,
  input  logic                 dec_stop_warp_i,
  input  logic [WidW-1:0]      dec_decoded_warp_id_i,
  input  logic [PcWidth-1:0]   dec_decoded_next_pc_i
);

  localparam int unsigned CredW = $clog2(IbDepthPerWarp + 1);

  // Internal storage uses the shared package types; widths must agree.
  if (PcWidth != $bits(pc_t) || WarpWidth != $bits(act_mask_t) ||
      WidW != $bits(wid_t)) begin : g_width_check
    $error("warp_fetch_scheduler parameters disagree with bgpu_fetch_pkg widths");
  end

  warp_state_e      state_q  [NumWarps];
  pc_t              pc_q     [NumWarps];
  act_mask_t        mask_q   [NumWarps];
  logic [CredW-1:0] credit_q [NumWarps];

  logic [NumWarps-1:0] eligible;
  logic [NumWarps-1:0] fetch_hs;
  logic [NumWarps-1:0] dec_hit;
  logic                grant_valid;
  wid_t                grant;
  logic                handshake;

  warp_rr_arbiter #(.N(NumWarps)) u_arb (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .req     (eligible),
    .advance (handshake),
    .valid   (grant_valid),
    .grant   (grant)
  );

  assign handshake     = grant_valid && ic_ready_i;
  assign fe_valid_o    = grant_valid;
  assign fe_warp_id_o  = grant;
  assign fe_pc_o       = pc_q[grant];
  assign fe_act_mask_o = mask_q[grant];

  always_comb begin
    eligible       = '0;
    fetch_hs       = '0;
    dec_hit        = '0;
    warp_active_o  = '0;
    warp_stopped_o = '0;
    for (int w = 0; w < int'(NumWarps); w++) begin
      eligible[w]       = (state_q[w] == WARP_READY) && (credit_q[w] != '0);
      fetch_hs[w]       = handshake && (grant == wid_t'(w));
      dec_hit[w]        = dec_decoded_i && (dec_decoded_warp_id_i == wid_t'(w));
      warp_active_o[w]  = (state_q[w] == WARP_READY) || (state_q[w] == WARP_WAIT);
      warp_stopped_o[w] = (state_q[w] == WARP_STOPPED);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < int'(NumWarps); w++) begin
        state_q[w]  <= WARP_IDLE;
        pc_q[w]     <= pc_t'(StartPc);
        mask_q[w]   <= '1;
        credit_q[w] <= CredW'(IbDepthPerWarp);
      end
    end else begin
      for (int w = 0; w < int'(NumWarps); w++) begin
        // A pop and a fetch on the same warp cancel out.
        if (fetch_hs[w] && !ib_pop_i[w]) begin
          credit_q[w] <= credit_q[w] - 1'b1;
        end else if (ib_pop_i[w] && !fetch_hs[w] &&
                     credit_q[w] != CredW'(IbDepthPerWarp)) begin
          credit_q[w] <= credit_q[w] + 1'b1;
        end

        case (state_q[w])
          WARP_IDLE, WARP_STOPPED: begin
            if (set_ready_i) begin
              state_q[w] <= WARP_READY;
              pc_q[w]    <= pc_t'(StartPc);
              mask_q[w]  <= '1;
            end
          end
          WARP_READY: begin
            if (fetch_hs[w]) state_q[w] <= WARP_WAIT;
          end
          WARP_WAIT: begin
            if (dec_hit[w]) begin
              if (dec_stop_warp_i) begin
                state_q[w] <= WARP_STOPPED;
              end else begin
                state_q[w] <= WARP_READY;
                pc_q[w]    <= dec_decoded_next_pc_i;
              end
            end
          end
          default: state_q[w] <= WARP_IDLE;
        endcase
      end
    end
  end

`ifdef WARP_FETCH_SCHED_ASSERT_EN
  a_dec_not_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dec_decoded_i |-> state_q[dec_decoded_warp_id_i] == WARP_WAIT);

  for (genvar g = 0; g < int'(NumWarps); g++) begin : g_credit_assert
    a_credit_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (ib_pop_i[g] && !fetch_hs[g]) |-> credit_q[g] != CredW'(IbDepthPerWarp));
  end

  a_fe_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fe_valid_o && !ic_ready_i) |=> (fe_valid_o && $stable(fe_pc_o) &&
      $stable(fe_act_mask_o) && $stable(fe_warp_id_o)));
`endif

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
module tb_warp_fetch_scheduler;

  localparam int NW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          set_ready_i = 1'b0;
  logic [NW-1:0] warp_active_o;
  logic [NW-1:0] warp_stopped_o;
  logic [NW-1:0] ib_pop_i = '0;
  logic          ic_ready_i = 1'b0;
  logic          fe_valid_o;
  logic [15:0]   fe_pc_o;
  logic [3:0]    fe_act_mask_o;
  logic [2:0]    fe_warp_id_o;
  logic          dec_decoded_i = 1'b0;
  logic          dec_stop_warp_i = 1'b0;
  logic [2:0]    dec_decoded_warp_id_i = '0;
  logic [15:0]   dec_decoded_next_pc_i = '0;

  int checks = 0;
  int failures = 0;
  logic [22:0] exp_q[$];   // {warp_id, pc, mask}

  warp_fetch_scheduler #(
    .PcWidth(16), .NumWarps(NW), .WarpWidth(4), .IbDepthPerWarp(2), .StartPc(0)
  ) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .set_ready_i           (set_ready_i),
    .warp_active_o         (warp_active_o),
    .warp_stopped_o        (warp_stopped_o),
    .ib_pop_i              (ib_pop_i),
    .ic_ready_i            (ic_ready_i),
    .fe_valid_o            (fe_valid_o),
    .fe_pc_o               (fe_pc_o),
    .fe_act_mask_o         (fe_act_mask_o),
    .fe_warp_id_o          (fe_warp_id_o),
    .dec_decoded_i         (dec_decoded_i),
    .dec_stop_warp_i       (dec_stop_warp_i),
    .dec_decoded_warp_id_i (dec_decoded_warp_id_i),
    .dec_decoded_next_pc_i (dec_decoded_next_pc_i)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every accepted fetch must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && fe_valid_o && ic_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL fetch_unexpected got id=%0d pc=%0h expected none",
                 fe_warp_id_o, fe_pc_o);
      end else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        if ({fe_warp_id_o, fe_pc_o, fe_act_mask_o} !== e) begin
          failures++;
          $display("FAIL fetch got id=%0d pc=%0h mask=%0h expected id=%0d pc=%0h mask=%0h",
                   fe_warp_id_o, fe_pc_o, fe_act_mask_o, e[22:20], e[19:4], e[3:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int id, input logic [15:0] pc);
    exp_q.push_back({3'(id), pc, 4'hf});
  endtask

  task automatic decode(input int id, input logic [15:0] pc, input logic stop);
    dec_decoded_i         = 1'b1;
    dec_decoded_warp_id_i = 3'(id);
    dec_decoded_next_pc_i = pc;
    dec_stop_warp_i       = stop;
    tick();
    dec_decoded_i   = 1'b0;
    dec_stop_warp_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout got=%0d pending expected=0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 32'(fe_valid_o), 0);
    chk("rst_active", 32'(warp_active_o), 0);
    chk("rst_stopped", 32'(warp_stopped_o), 0);
    #1 rst_ni = 1'b1;
    tick();

    // Start: all warps fetched in order at StartPc
    for (int w = 0; w < NW; w++) push(w, 16'h0000);
    ic_ready_i  = 1'b1;
    set_ready_i = 1'b1;
    tick();
    set_ready_i = 1'b0;
    drain("start");
    @(negedge clk_i);
    chk("start_idle_valid", 32'(fe_valid_o), 0);
    chk("start_active", 32'(warp_active_o), 32'hff);
    tick();

    // Decode warp 3 to a new PC; it is fetched there
    push(3, 16'h0040);
    decode(3, 16'h0040, 1'b0);
    drain("dec3");

    // Stall with warp 2 granted; warp 5 becoming ready must not steal the slot
    ic_ready_i = 1'b0;
    decode(2, 16'h0022, 1'b0);
    dec_decoded_i = 1'b1; dec_decoded_warp_id_i = 3'd5; dec_decoded_next_pc_i = 16'h0055;
    @(negedge clk_i);
    chk("stall1", {fe_valid_o, 9'd0, 3'(fe_warp_id_o), fe_pc_o}, {1'b1, 9'd0, 3'd2, 16'h0022});
    tick();
    dec_decoded_i = 1'b0;
    @(negedge clk_i);
    chk("stall2", {fe_valid_o, 9'd0, 3'(fe_warp_id_o), fe_pc_o}, {1'b1, 9'd0, 3'd2, 16'h0022});
    tick();
    @(negedge clk_i);
    chk("stall3", {fe_valid_o, 9'd0, 3'(fe_warp_id_o), fe_pc_o}, {1'b1, 9'd0, 3'd2, 16'h0022});
    push(2, 16'h0022);
    push(5, 16'h0055);
    tick();
    ic_ready_i = 1'b1;
    drain("stall_release");

    // Credit exhaustion on warp 0 and refill by one pop
    push(0, 16'h0010);
    decode(0, 16'h0010, 1'b0);
    drain("w0_second");
    decode(0, 16'h0012, 1'b0);
    @(negedge clk_i);
    chk("w0_no_credit", 32'(fe_valid_o), 0);
    chk("w0_active", 32'(warp_active_o[0]), 1);
    tick();
    push(0, 16'h0012);
    ib_pop_i[0] = 1'b1;
    tick();
    ib_pop_i[0] = 1'b0;
    drain("w0_refill");

    // Stop warp 3
    decode(3, 16'h0000, 1'b1);
    @(negedge clk_i);
    chk("w3_stopped", 32'(warp_stopped_o[3]), 1);
    chk("w3_inactive", 32'(warp_active_o[3]), 0);
    tick();

    // Stop on warp 6 together with set_ready: 6 stays stopped, 3 restarts
    dec_decoded_i = 1'b1; dec_decoded_warp_id_i = 3'd6; dec_stop_warp_i = 1'b1;
    set_ready_i   = 1'b1;
    tick();
    dec_decoded_i = 1'b0; dec_stop_warp_i = 1'b0; set_ready_i = 1'b0;
    @(negedge clk_i);
    chk("coincide_stopped", 32'(warp_stopped_o), 32'h40);
    chk("w3_restarted", 32'(warp_active_o[3]), 1);
    chk("coincide_valid", 32'(fe_valid_o), 0);
    tick();
    push(6, 16'h0000);
    set_ready_i = 1'b1;
    tick();
    set_ready_i = 1'b0;
    drain("w6_restart");

    // Simultaneous fetch and pop on warp 1 at credit 1 keeps credit at 1
    ic_ready_i = 1'b0;
    decode(1, 16'h0080, 1'b0);
    push(1, 16'h0080);
    ic_ready_i  = 1'b1;
    ib_pop_i[1] = 1'b1;
    tick();
    ib_pop_i[1] = 1'b0;
    drain("w1_pop_hs");
    push(1, 16'h0082);
    decode(1, 16'h0082, 1'b0);
    drain("w1_last_credit");
    decode(1, 16'h0084, 1'b0);
    @(negedge clk_i);
    chk("w1_credit_empty", 32'(fe_valid_o), 0);
    tick();

    // Saturation: warp 7 at credit 1, three pops leave it at 2
    repeat (3) begin
      ib_pop_i[7] = 1'b1;
      tick();
    end
    ib_pop_i[7] = 1'b0;
    push(7, 16'h0070);
    decode(7, 16'h0070, 1'b0);
    drain("w7_a");
    push(7, 16'h0072);
    decode(7, 16'h0072, 1'b0);
    drain("w7_b");
    decode(7, 16'h0074, 1'b0);
    @(negedge clk_i);
    chk("w7_saturated", 32'(fe_valid_o), 0);
    tick();

    // Reset in the middle of a stalled fetch
    ic_ready_i = 1'b0;
    decode(4, 16'h0044, 1'b0);
    @(negedge clk_i);
    chk("w4_pending", {fe_valid_o, 28'd0, 3'(fe_warp_id_o)}, {1'b1, 28'd0, 3'd4});
    tick();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("midrst_valid", 32'(fe_valid_o), 0);
    chk("midrst_active", 32'(warp_active_o), 0);
    chk("midrst_stopped", 32'(warp_stopped_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();
    for (int w = 0; w < NW; w++) push(w, 16'h0000);
    ic_ready_i  = 1'b1;
    set_ready_i = 1'b1;
    tick();
    set_ready_i = 1'b0;
    drain("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/warp_fetch_scheduler.md
WARP_FETCH_SCHEDULER -- requirements
Module: warp_fetch_scheduler

Interface
REQ-001 SHALL have parameter PcWidth, default 16, program-counter width.
REQ-002 SHALL have parameter NumWarps, default 8, number of warps (>=2).
REQ-003 SHALL have parameter WarpWidth, default 4, threads per warp (active-mask width).
REQ-004 SHALL have parameter IbDepthPerWarp, default 4, instruction-buffer entries per warp, which is also the initial credit count.
REQ-005 SHALL have parameter StartPc, default 0, PC loaded on start.
REQ-006 SHALL have ports: clk_i input 1, single clock; rst_ni input 1, asynchronous active-low reset.
REQ-007 SHALL have ports: set_ready_i input 1, start/restart request; warp_active_o output NumWarps, warp in READY or WAIT; warp_stopped_o output NumWarps, warp in STOPPED.
REQ-008 SHALL have port ib_pop_i input NumWarps, per-warp instruction-buffer dequeue, returning one credit.
REQ-009 SHALL have ports: ic_ready_i input 1; fe_valid_o output 1; fe_pc_o output PcWidth; fe_act_mask_o output WarpWidth; fe_warp_id_o output $clog2(NumWarps).
REQ-010 SHALL have ports: dec_decoded_i input 1; dec_stop_warp_i input 1; dec_decoded_warp_id_i input $clog2(NumWarps); dec_decoded_next_pc_i input PcWidth.

Function
REQ-011 SHALL hold per-warp state IDLE/READY/WAIT/STOPPED, a PC, an active mask and a credit counter of width $clog2(IbDepthPerWarp+1).
REQ-012 SHALL, when set_ready_i is high, move every IDLE or STOPPED warp to READY with PC=StartPc and mask all-ones on the next edge; READY and WAIT warps are unaffected; credits are kept.
REQ-013 SHALL treat a warp as eligible iff state==READY and credits>0.
REQ-014 SHALL select among eligible warps round-robin, starting at the warp after the last granted warp; fe_valid_o is high iff any warp is eligible; fe_* outputs are combinational from state (zero latency).
REQ-015 SHALL advance the round-robin pointer only on handshake (fe_valid_o && ic_ready_i); while fe_valid_o is high without ready, fe_pc_o/fe_act_mask_o/fe_warp_id_o SHALL stay stable.
REQ-016 SHALL, on handshake, move the granted warp READY->WAIT and decrement its credit; at most one fetch is outstanding per warp.
REQ-017 SHALL, on dec_decoded_i for a warp in WAIT, load PC=dec_decoded_next_pc_i and go READY, or go STOPPED if dec_stop_warp_i is high.
REQ-018 SHALL ignore dec_decoded_i naming a warp not in WAIT.
REQ-019 SHALL increment a warp's credit on ib_pop_i; a simultaneous handshake and pop on the same warp leaves the credit unchanged; a pop at credit==IbDepthPerWarp saturates.
REQ-020 SHALL apply a handshake of warp A and a decode of warp B!=A in the same cycle independently; a decode to STOPPED coinciding with set_ready_i leaves the warp STOPPED for one cycle, and it restarts on a later set_ready_i.
REQ-021 SHALL wrap PC arithmetic modulo 2^PcWidth (the PC is loaded, never incremented, here).

Reset
REQ-022 SHALL, while rst_ni is low, force all warps IDLE, PC=StartPc, mask all-ones, credits=IbDepthPerWarp, pointer=0; fe_valid_o=0, warp_active_o=0, warp_stopped_o=0; an assertion mid-fetch discards the outstanding fetch.

Configuration
REQ-023 SHALL, with WARP_FETCH_SCHED_ASSERT_EN defined, include assertions for: decode of a non-WAIT warp, credit overflow, and fe_* instability while valid&&!ready; without the macro, no assertion code is compiled and function is identical.

Structure
REQ-024 SHALL take pc_t, act_mask_t, wid_t and the warp-state enum from shared package bgpu_fetch_pkg.
REQ-025 SHALL implement selection in sub-module warp_rr_arbiter (request vector, grant index, advance strobe).

Verification
REQ-026 Reset, then set_ready_i with ic_ready_i=1, NumWarps=8 -> grants warps 0,1,2,...,7 in consecutive cycles, all fe_pc_o=StartPc, then fe_valid_o=0.
REQ-027 ic_ready_i=0 for 3 cycles with warp 2 granted -> fe_warp_id_o=2 and fe_pc_o stable for 3 cycles; pointer unchanged.
REQ-028 Decode of warp 3 with next_pc=0x40 -> warp 3 READY, next grant of warp 3 has fe_pc_o=0x40; with dec_stop_warp_i=1 -> warp_stopped_o[3]=1, warp_active_o[3]=0.
REQ-029 IbDepthPerWarp=2, no ib_pop_i -> warp 0 fetched twice, then ineligible; one ib_pop_i[0] -> eligible again after decode.
REQ-030 Same-cycle handshake on warp 1 and ib_pop_i[1] at credit 1 -> credit stays 1; rst_ni low mid-WAIT -> all outputs return to reset values.
